// File: rtl/apb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_ctrl_pkg
// Description : Shared types and helpers for the APB master controller:
//               FSM state encoding and the slave-select decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_ctrl_pkg;

    localparam int APB_NUM_SLAVES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_ctrl_state_e;

    // One-hot psel vector for a 4-bit slave index
    function automatic logic [APB_NUM_SLAVES-1:0] apb_sel_decode(input logic [3:0] idx);
        logic [APB_NUM_SLAVES-1:0] v_sel;
        v_sel      = '0;
        v_sel[idx] = 1'b1;
        return v_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_arbiter
// Description : Round-robin arbiter. Search begins one past the last
//               accepted requester; the pointer moves only on acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] r_last_grant;
    logic             w_found;
    int               w_pos;
    logic [IDX_W-1:0] w_pos_idx;

    // Pick the first active request after the last winner, wrapping around
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_pos     = 0;
        w_pos_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = int'(r_last_grant) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_pos_idx = IDX_W'(w_pos);
            if (!w_found && req[w_pos_idx]) begin
                w_found          = 1'b1;
                grant[w_pos_idx] = 1'b1;
                grant_idx        = w_pos_idx;
            end
        end
    end

    // Reset points at the top requester so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (advance && (|grant)) begin
            r_last_grant <= grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_ctrl
// Description : APB master sequencer. Arbitrates local requesters, runs the
//               granted transfer through SETUP/ACCESS, returns a one-cycle
//               response with read data / error status, and aborts stalled
//               slaves after TIMEOUT ACCESS cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_ctrl
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int PADDR_WIDTH  = 32,
    parameter int PWDATA_WIDTH = 32,
    parameter int PRDATA_WIDTH = 32,
    parameter int SEL_LSB      = 16,
    parameter int TIMEOUT      = 256
) (
    input  logic                              pclock,
    input  logic                              preset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*PADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*PWDATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [PRDATA_WIDTH-1:0]           rsp_rdata,
    output logic                              rsp_slverr,
    output logic                              busy,
    output logic [PADDR_WIDTH-1:0]            paddr,
    output logic                              prwd,
    output logic [PWDATA_WIDTH-1:0]           pwdata,
    output logic [APB_NUM_SLAVES-1:0]         psel,
    output logic                              penable,
    input  logic                              pready,
    input  logic [PRDATA_WIDTH-1:0]           prdata,
    input  logic                              pslverr
);

    localparam int                 c_idx_w    = $clog2(NUM_REQ);
    // Width keeps a 1-bit counter legal when the timeout is disabled
    localparam int                 c_cnt_w    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit                 c_tmo_en   = (TIMEOUT > 0);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_ctrl_state_e         r_state;
    logic [NUM_REQ-1:0]      r_grant;
    logic [c_cnt_w-1:0]      r_wait_cnt;

    logic [NUM_REQ-1:0]      w_grant;
    logic [c_idx_w-1:0]      w_grant_idx;
    logic                    w_advance;
    logic [PADDR_WIDTH-1:0]  w_addr;
    logic [PWDATA_WIDTH-1:0] w_wdata;
    logic                    w_write;

    assign w_advance = (r_state == IDLE) && (|req_valid);
    assign w_addr    = req_addr[w_grant_idx*PADDR_WIDTH +: PADDR_WIDTH];
    assign w_wdata   = req_wdata[w_grant_idx*PWDATA_WIDTH +: PWDATA_WIDTH];
    assign w_write   = req_write[w_grant_idx];

    // Acceptance handshake is the only combinational output
    assign req_ready = (r_state == IDLE) ? w_grant : '0;
    assign busy      = (r_state != IDLE);

    apb_rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_arbiter (
        .clk       (pclock),
        .rst       (preset),
        .req       (req_valid),
        .advance   (w_advance),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Transfer sequencer with registered APB drive and response outputs
    always_ff @(posedge pclock) begin
        if (preset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_wait_cnt <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
            paddr      <= '0;
            prwd       <= 1'b0;
            pwdata     <= '0;
            psel       <= '0;
            penable    <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        paddr      <= w_addr;
                        prwd       <= w_write;
                        pwdata     <= w_wdata;
                        psel       <= apb_sel_decode(w_addr[SEL_LSB +: 4]);
                        penable    <= 1'b0;
                        r_grant    <= w_grant;
                        r_wait_cnt <= '0;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel       <= '0;
                        penable    <= 1'b0;
                        rsp_valid  <= r_grant;
                        rsp_rdata  <= prwd ? '0 : prdata;
                        rsp_slverr <= pslverr;
                        r_state    <= RESP;
                    end else if (c_tmo_en && (r_wait_cnt == c_tmo_last)) begin
                        psel       <= '0;
                        penable    <= 1'b0;
                        rsp_valid  <= r_grant;
                        rsp_rdata  <= '0;
                        rsp_slverr <= 1'b1;
                        r_state    <= RESP;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_ctrl
// Description : Self-checking bench for apb_master_ctrl: directed scenarios
//               followed by randomized traffic against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_ctrl;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 8;
    localparam int SLSB = 16;

    logic                 pclock = 1'b0;
    logic                 preset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ-1:0]      req_write;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_slverr;
    logic                 busy;
    logic [AW-1:0]        paddr;
    logic                 prwd;
    logic [DW-1:0]        pwdata;
    logic [15:0]          psel;
    logic                 penable;
    logic                 pready;
    logic [DW-1:0]        prdata;
    logic                 pslverr;

    apb_master_ctrl #(
        .NUM_REQ      (NREQ),
        .PADDR_WIDTH  (AW),
        .PWDATA_WIDTH (DW),
        .PRDATA_WIDTH (DW),
        .SEL_LSB      (SLSB),
        .TIMEOUT      (TMO)
    ) dut (
        .pclock     (pclock),
        .preset     (preset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .busy       (busy),
        .paddr      (paddr),
        .prwd       (prwd),
        .pwdata     (pwdata),
        .psel       (psel),
        .penable    (penable),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr)
    );

    always #5 pclock = ~pclock;

    int        checks   = 0;
    int        failures = 0;
    int        last_g   = NREQ - 1;
    bit [3:0]  pend     = '0;
    bit [31:0] m_addr  [NREQ];
    bit [31:0] m_wdata [NREQ];
    bit        m_write [NREQ];

    task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclock);
        #2;
    endtask

    // Next winner: first pending requester after the last one served
    function automatic int rr_pick(input bit [3:0] p, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic post(input int i, input bit [31:0] a, input bit w, input bit [31:0] d);
        m_addr[i]  = a;
        m_write[i] = w;
        m_wdata[i] = d;
        req_addr[i*AW +: AW]  = a;
        req_write[i]          = w;
        req_wdata[i*DW +: DW] = d;
        pend[i]   = 1'b1;
        req_valid = pend;
    endtask

    // One complete transfer starting in IDLE with requests already applied
    task automatic run_xfer(input int waits, input bit tmo, input bit err,
                            input bit [31:0] rd, input string tag, output int g);
        int        n_acc;
        bit [15:0] exp_sel;
        bit [31:0] exp_rd;
        #1;
        g = rr_pick(pend, last_g);
        chk(tag, "req_ready", req_ready, (g < 0) ? 0 : (1 << g));
        if (g < 0) return;
        last_g  = g;
        exp_sel = 16'h0001 << m_addr[g][SLSB +: 4];
        tick();
        pend[g]   = 1'b0;
        req_valid = pend;
        pready    = 1'($urandom_range(0, 1));
        prdata    = rd;
        pslverr   = err;
        #1;
        chk(tag, "setup_busy", busy, 1);
        chk(tag, "setup_psel", psel, exp_sel);
        chk(tag, "setup_penable", penable, 0);
        chk(tag, "setup_paddr", paddr, m_addr[g]);
        chk(tag, "setup_prwd", prwd, m_write[g]);
        chk(tag, "setup_pwdata", pwdata, m_wdata[g]);
        chk(tag, "setup_ready", req_ready, 0);
        n_acc = tmo ? TMO : waits + 1;
        for (int i = 0; i < n_acc; i++) begin
            tick();
            pready = !tmo && (i == n_acc - 1);
            #1;
            chk(tag, "acc_penable", penable, 1);
            chk(tag, "acc_psel", psel, exp_sel);
            chk(tag, "acc_paddr", paddr, m_addr[g]);
            chk(tag, "acc_rsp_valid", rsp_valid, 0);
        end
        tick();
        pready = 1'b0;
        prdata = $urandom;
        exp_rd = (tmo || m_write[g]) ? 32'h0 : rd;
        chk(tag, "rsp_valid", rsp_valid, 1 << g);
        chk(tag, "rsp_rdata", rsp_rdata, exp_rd);
        chk(tag, "rsp_slverr", rsp_slverr, tmo | err);
        chk(tag, "rsp_psel", psel, 0);
        chk(tag, "rsp_penable", penable, 0);
        tick();
        chk(tag, "idle_rsp_valid", rsp_valid, 0);
        chk(tag, "idle_busy", busy, 0);
    endtask

    initial begin
        int g;
        preset    = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        tick();
        tick();
        preset = 1'b0;
        #1;
        chk("reset", "req_ready", req_ready, 0);
        chk("reset", "rsp_valid", rsp_valid, 0);
        chk("reset", "rsp_rdata", rsp_rdata, 0);
        chk("reset", "rsp_slverr", rsp_slverr, 0);
        chk("reset", "busy", busy, 0);
        chk("reset", "paddr", paddr, 0);
        chk("reset", "prwd", prwd, 0);
        chk("reset", "pwdata", pwdata, 0);
        chk("reset", "psel", psel, 0);
        chk("reset", "penable", penable, 0);
        tick();

        post(0, 32'h0003_0010, 1'b1, 32'hA5A5_0001);
        run_xfer(0, 1'b0, 1'b0, 32'h1234_5678, "wr0", g);

        post(1, 32'h000C_0104, 1'b0, 32'h0);
        run_xfer(3, 1'b0, 1'b0, 32'hDEAD_BEEF, "rd3w", g);

        post(3, 32'h0007_0000, 1'b0, 32'h0);
        run_xfer(0, 1'b0, 1'b1, 32'hCAFE_0001, "slverr", g);
        post(0, 32'h0002_0040, 1'b0, 32'h0);
        run_xfer(1, 1'b0, 1'b0, 32'h0BAD_F00D, "after_err", g);

        post(1, 32'h000F_0008, 1'b0, 32'h0);
        run_xfer(0, 1'b1, 1'b0, 32'h5555_AAAA, "timeout", g);

        // Abort a transfer mid-ACCESS with reset
        post(2, 32'h0005_0020, 1'b1, 32'h7777_0002);
        #1;
        chk("rst_mid", "req_ready", req_ready, 4'b0100);
        tick();
        pend[2]   = 1'b0;
        req_valid = pend;
        tick();
        tick();
        #1;
        chk("rst_mid", "in_access", penable, 1);
        preset = 1'b1;
        tick();
        #1;
        chk("rst_mid", "psel", psel, 0);
        chk("rst_mid", "penable", penable, 0);
        chk("rst_mid", "busy", busy, 0);
        chk("rst_mid", "rsp_valid", rsp_valid, 0);
        preset = 1'b0;
        last_g = NREQ - 1;
        tick();
        chk("rst_mid", "no_rsp", rsp_valid, 0);

        // All four requesting continuously
        for (int i = 0; i < NREQ; i++) post(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
        for (int k = 0; k < 5; k++) begin
            run_xfer(0, 1'b0, 1'b0, $urandom, "rr", g);
            chk("rr", "order", g, k % NREQ);
            post(g, $urandom, 1'($urandom_range(0, 1)), $urandom);
        end

        // Randomized traffic, including requests withdrawn before grant
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    post(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
                else if (pend[i] && $urandom_range(0, 7) == 0)
                    pend[i] = 1'b0;
            end
            if (pend == 0) post(int'($urandom_range(0, NREQ - 1)), $urandom, 1'($urandom_range(0, 1)), $urandom);
            req_valid = pend;
            run_xfer(int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 1)), $urandom, "rand", g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Sequencer for the APB master bus. Arbitrates round-robin among `NUM_REQ` local requesters. Runs the granted transfer through the APB SETUP/ACCESS phases on the master-interface signals. Returns read data and error status to the requester. Sits between on-chip initiators (test sequencer, DMA, CPU bridge) and the APB master interface that feeds up to 16 slaves.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `PADDR_WIDTH`, 32: APB address width.
- `PWDATA_WIDTH`, 32: write data width.
- `PRDATA_WIDTH`, 32: read data width.
- `SEL_LSB`, 16: `paddr[SEL_LSB+3:SEL_LSB]` selects one of 16 `psel` bits.
- `TIMEOUT`, 256: maximum ACCESS cycles without `pready`; 0 disables the timeout.

Ports:
- `pclock` in 1: sole clock, rising edge.
- `preset` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request.
- `req_ready` out NUM_REQ: one-hot; request accepted this cycle.
- `req_addr` in NUM_REQ*PADDR_WIDTH: flattened, requester i at slice i.
- `req_write` in NUM_REQ: 1 = write.
- `req_wdata` in NUM_REQ*PWDATA_WIDTH: flattened write data.
- `rsp_valid` out NUM_REQ: one-hot, single-cycle completion pulse.
- `rsp_rdata` out PRDATA_WIDTH: read data; 0 for writes and timeouts.
- `rsp_slverr` out 1: `pslverr` or timeout.
- `busy` out 1: state ≠ IDLE.
- `paddr` out PADDR_WIDTH; `prwd` out 1; `pwdata` out PWDATA_WIDTH; `psel` out 16; `penable` out 1: APB master drive.
- `pready` in 1; `prdata` in PRDATA_WIDTH; `pslverr` in 1: APB slave response.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any `req_valid` is high, the arbiter grants one requester.
  - `req_ready[g]` goes high combinationally in the same cycle.
  - The controller latches addr, write, wdata and grant id, then moves to SETUP.
  - If no request is pending, it stays in IDLE.
- SETUP: drive `psel[paddr[SEL_LSB+3:SEL_LSB]]`=1, `penable`=0; `paddr`/`prwd`/`pwdata` from latched values. Always goes to ACCESS.
- ACCESS:
  - `penable`=1; `psel`, `paddr`, `prwd` and `pwdata` are held stable.
  - On `pready`=1, capture `prdata` (reads only) and `pslverr`, then go to RESP.
  - Otherwise increment the wait counter.
  - When the counter reaches `TIMEOUT`-1 with `pready` still low, go to RESP with slverr=1 and rdata=0.
- RESP:
  - `psel`/`penable` are 0.
  - `rsp_valid[g]`=1 for exactly one cycle with the captured rdata/slverr.
  - Next state is IDLE.
- Arbitration:
  - Round-robin; the search starts at (last_grant+1) mod NUM_REQ.
  - Reset sets last_grant = NUM_REQ-1, so requester 0 wins first.
  - last_grant updates only on acceptance.
- Requesters must hold `req_*` stable while `req_valid` is high until `req_ready`.
- A requester may deassert `req_valid` before grant; this is legal, and no transfer is issued for it.
- Wait counter: $clog2(TIMEOUT+1) bits; cleared on SETUP entry; saturates, never wraps.
- Reset (any state, including mid-ACCESS):
  - Next edge: all outputs 0, state IDLE, counter 0, last_grant NUM_REQ-1.
  - An aborted transfer produces no `rsp_valid`.
- Reset values: `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_slverr`, `busy`, `paddr`, `prwd`, `pwdata`, `psel`, `penable` are all 0.

## Timing
- Acceptance at cycle N, SETUP at N+1, ACCESS at N+2.
- With `pready`=1 at N+2: RESP (`rsp_valid`) at N+3, next acceptance at N+4.
- Minimum 4 cycles per transfer.
- Each extra wait cycle adds 1 cycle.
- Timeout: `rsp_valid` follows TIMEOUT ACCESS cycles.
- All APB outputs and `rsp_*` are registered; only `req_ready` is combinational (from state, `req_valid`, last_grant).
- `pready`/`pslverr`/`prdata` are sampled only in ACCESS; ignored elsewhere.

## Structure
- Package `apb_ctrl_pkg`:
  - state enum `apb_ctrl_state_e` {IDLE, SETUP, ACCESS, RESP}.
  - function `apb_sel_decode(idx[3:0])` returning the 16-bit one-hot.
  - constant `APB_NUM_SLAVES`=16.
- Sub-module `apb_rr_arbiter`:
  - Parameter NUM_REQ; inputs req, advance; outputs one-hot grant, grant index.
  - Holds last_grant.
- Top (`apb_master_ctrl`) holds the FSM, the latches and the wait counter.

## Test plan
- Single write: req0 writes addr 0x0003_0010, data 0xA5A5_0001; pready=1 first ACCESS -> psel=0x0008 at N+1, penable at N+2, `rsp_valid`=0001 at N+3, slverr 0.
- Read with 3 wait states: prdata=0xDEAD_BEEF -> `rsp_rdata`=0xDEAD_BEEF at N+6; psel/paddr stable throughout ACCESS.
- Round-robin: all 4 `req_valid` held high -> grant order 0,1,2,3,0; one transfer every 4 cycles.
- Slave error: pslverr=1 with pready -> `rsp_slverr`=1; the next transfer is unaffected.
- Timeout: TIMEOUT=8, pready held 0 -> `rsp_valid` after 8 ACCESS cycles, slverr=1, rdata=0, psel cleared.
- Reset mid-ACCESS -> next edge psel=0, penable=0, busy=0, no `rsp_valid`; first post-reset grant goes to req0.
